onchip_memory_arbiter: RTL and testbench
========================================

# onchip_memory_arbiter

Shares one 64-bit port of the dual-port on-chip memory (16384 × 64, byte-enabled) between two Avalon-MM-style burst masters in the danmaku datapath, e.g. the frame renderer reading glyph data and the host DMA writing it. Round-robin arbitration is granted per burst. The block generates sequential addresses and drives the memory port's chipselect, write, byteenable and data. It returns read data with a fixed latency.

## Interface
Parameters:
- ADDR_W, 14, word address width; must match the memory port.
- DATA_W, 64, data width.
- BE_W, 8, byte-enable width (DATA_W/8).
- BURST_W, 4, burstcount width; legal bursts are 1..15.

Ports:
- clk  in  1  single clock for the block and its memory port.
- reset_n  in  1  synchronous, active-low reset.
- mN_address  in  ADDR_W  burst start word address (N = 0, 1).
- mN_burstcount  in  BURST_W  beats in the burst; 0 is treated as 1.
- mN_read / mN_write  in  1  request strobes; when both are high, the request is a write.
- mN_writedata  in  DATA_W  write beat data.
- mN_byteenable  in  BE_W  write beat byte lanes.
- mN_waitrequest  out  1  high = command or beat not accepted.
- mN_readdata  out  DATA_W  read data, valid when readdatavalid is high.
- mN_readdatavalid  out  1  one pulse per returned read beat.
- mem_address  out  ADDR_W  to memory address port.
- mem_chipselect  out  1  to memory chipselect.
- mem_write  out  1  to memory write.
- mem_byteenable  out  BE_W  to memory byteenable.
- mem_writedata  out  DATA_W  to memory writedata.
- mem_readdata  in  DATA_W  from memory; valid one cycle after a read address is presented.

## Operation
- FSM states are IDLE, RD and WR. Registered state: grant (1 bit), last_grant (1 bit), base address, beat counter, beat total, and a readdatavalid pipe.
- IDLE:
  - Both mN_waitrequest are high. The memory port is idle: chipselect=0, write=0.
  - If exactly one master requests, that master wins.
  - If both masters request, the master ≠ last_grant wins.
  - On a win the block latches grant, address, burstcount (0→1) and direction, sets last_grant = winner, and goes to RD or WR.
- RD:
  - In the first RD cycle, the granted master's waitrequest is low; this is command acceptance, and the master may drop read afterwards.
  - On each RD cycle, including the first, the block drives chipselect=1, write=0, byteenable all ones, and mem_address = base + beat. The beat counter then increments.
  - After the last beat is issued, the FSM returns to IDLE.
  - mN_readdatavalid for the granted master is a registered copy of "beat issued". It is never asserted for the other master.
  - mN_readdata = mem_readdata for both masters.
- WR:
  - The granted master's waitrequest is low on every WR cycle.
  - A beat is accepted when mN_write is high. On that cycle the block drives chipselect=1, write=1, address = base + beat, and passes writedata and byteenable through. The beat counter increments.
  - If mN_write is low, chipselect and write are 0 and the counter holds; the master has stalled.
  - After the last accepted beat, the FSM returns to IDLE.
- The non-granted master always sees waitrequest=1 and readdatavalid=0.
- Address arithmetic is modulo 2^ADDR_W: a burst that crosses 16383 wraps to 0.
- Reset values: state=IDLE, last_grant=1 (so m0 wins the first contention), counters=0, both readdatavalid=0, both waitrequest=1, mem_chipselect=0, mem_write=0, mem_address=0.
- Reset asserted mid-burst abandons the burst. Beats already written stay in memory. Read beats still in the pipe are not returned.

## Timing
- Arbitration takes 1 cycle; the IDLE cycle issues nothing to memory.
- Read burst, with request high at cycle T0 while in IDLE:
  - Address beat 0 and waitrequest low at T1.
  - readdatavalid for beat k at T2+k.
  - Back in IDLE at T1+burstcount.
- Write burst, with request at T0: beat 0 can be written at T1 at the earliest. The FSM enters IDLE the cycle after the final accepted beat.
- Minimum gap between bursts is 1 IDLE cycle. The last read beat's readdatavalid overlaps that IDLE cycle, which causes no conflict.
- A master must hold its command stable until waitrequest is low. The block does not accept a new command from the same master in the same cycle it returns to IDLE.

## Test plan
- Single read: memory preloaded with word 0x10 = 0x0123456789ABCDEF; m0 reads address 0x10, burstcount 1 -> waitrequest low at T1; m0_readdatavalid at T2 with 0x0123456789ABCDEF; m1 sees no valid.
- Write burst with stall: m1 writes 4 beats at 0x100 with byteenable 0xFF and deasserts write for 2 cycles after beat 1 -> memory words 0x100..0x103 hold the data, no extra writes occur, and the FSM is in IDLE the cycle after beat 3.
- Contention: m0 and m1 request simultaneously out of reset, repeated 4 times -> grant order m0, m1, m0, m1, with one IDLE cycle between bursts.
- Wrap: m0 reads 3 beats from 0x3FFF -> mem_address sequence 0x3FFF, 0x0000, 0x0001; 3 readdatavalid pulses.
- Burstcount 0 and read+write: burstcount 0 produces exactly 1 beat; read and write asserted together performs a write.
- Reset mid-burst: reset_n low during beat 2 of an 8-beat read -> the next cycle shows IDLE, readdatavalid=0 and waitrequest=1; after release, m0 wins the first contention.

Source files
------------

// File: rtl/onchip_memory_arbiter.sv
// Round-robin burst arbiter sharing one port of the 16384x64 on-chip memory
// between two Avalon-MM-style burst masters; read data returns one cycle after address.
//
// state | meaning
// IDLE  | no burst owned; arbitrate between requesting masters
// RD    | issue one read beat per cycle for the granted master
// WR    | issue a write beat on each cycle the granted master holds write
module onchip_memory_arbiter #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 64,
   parameter int BE_W    = 8,
   parameter int BURST_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [ADDR_W-1:0]  m0_address,
   input  logic [BURST_W-1:0] m0_burstcount,
   input  logic               m0_read,
   input  logic               m0_write,
   input  logic [DATA_W-1:0]  m0_writedata,
   input  logic [BE_W-1:0]    m0_byteenable,
   output logic               m0_waitrequest,
   output logic [DATA_W-1:0]  m0_readdata,
   output logic               m0_readdatavalid,
   input  logic [ADDR_W-1:0]  m1_address,
   input  logic [BURST_W-1:0] m1_burstcount,
   input  logic               m1_read,
   input  logic               m1_write,
   input  logic [DATA_W-1:0]  m1_writedata,
   input  logic [BE_W-1:0]    m1_byteenable,
   output logic               m1_waitrequest,
   output logic [DATA_W-1:0]  m1_readdata,
   output logic               m1_readdatavalid,
   output logic [ADDR_W-1:0]  mem_address,
   output logic               mem_chipselect,
   output logic               mem_write,
   output logic [BE_W-1:0]    mem_byteenable,
   output logic [DATA_W-1:0]  mem_writedata,
   input  logic [DATA_W-1:0]  mem_readdata
);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t             state_q, state_d;
   logic               grant_q, grant_d;
   logic               last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [BURST_W-1:0] beat_q, beat_d;
   logic [BURST_W-1:0] total_q, total_d;
   logic [1:0]         rdv_q, rdv_d;

   logic               req0, req1, win, last_beat, cmd_ack;
   logic               sel_write;
   logic [DATA_W-1:0]  sel_wdata;
   logic [BE_W-1:0]    sel_be;
   logic [ADDR_W-1:0]  beat_addr;

   assign req0      = m0_read | m0_write;
   assign req1      = m1_read | m1_write;
   assign sel_write = grant_q ? m1_write : m0_write;
   assign sel_wdata = grant_q ? m1_writedata : m0_writedata;
   assign sel_be    = grant_q ? m1_byteenable : m0_byteenable;
   assign beat_addr = base_q + ADDR_W'(beat_q);
   assign last_beat = (beat_q == total_q - BURST_W'(1));

   // Reads are acknowledged only on their first beat; writes hold the handshake open per beat.
   assign cmd_ack = (state_q == RD && beat_q == '0) || (state_q == WR);

   assign m0_waitrequest   = !(cmd_ack && !grant_q);
   assign m1_waitrequest   = !(cmd_ack && grant_q);
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rdv_q[0];
   assign m1_readdatavalid = rdv_q[1];

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_grant_d   = last_grant_q;
      base_d         = base_q;
      beat_d         = beat_q;
      total_d        = total_q;
      rdv_d          = '0;
      win            = 1'b0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               win          = (req0 && req1) ? ~last_grant_q : req1;
               grant_d      = win;
               last_grant_d = win;
               base_d       = win ? m1_address : m0_address;
               total_d      = win ? m1_burstcount : m0_burstcount;
               if (total_d == '0) total_d = BURST_W'(1);
               beat_d       = '0;
               state_d      = (win ? m1_write : m0_write) ? WR : RD;
            end
         end
         RD: begin
            mem_chipselect = 1'b1;
            mem_address    = beat_addr;
            mem_byteenable = '1;
            rdv_d[grant_q] = 1'b1;
            if (last_beat) begin
               beat_d  = '0;
               state_d = IDLE;
            end else begin
               beat_d = beat_q + BURST_W'(1);
            end
         end
         WR: begin
            if (sel_write) begin
               mem_chipselect = 1'b1;
               mem_write      = 1'b1;
               mem_address    = beat_addr;
               mem_byteenable = sel_be;
               mem_writedata  = sel_wdata;
               if (last_beat) begin
                  beat_d  = '0;
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + BURST_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         base_q       <= '0;
         beat_q       <= '0;
         total_q      <= '0;
         rdv_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         base_q       <= base_d;
         beat_q       <= beat_d;
         total_q      <= total_d;
         rdv_q        <= rdv_d;
      end
   end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Randomized bench for onchip_memory_arbiter: a burst-level model predicts grants,
// memory writes and read data into queues that a negedge monitor drains.
module tb_onchip_memory_arbiter;

   typedef struct packed {
      logic [13:0] a;
      logic [63:0] d;
      logic [7:0]  be;
   } wr_t;

   logic        clk;
   logic        reset_n;
   logic [13:0] m_address    [2];
   logic [3:0]  m_burstcount [2];
   logic        m_read       [2];
   logic        m_write      [2];
   logic [63:0] m_writedata  [2];
   logic [7:0]  m_byteenable [2];
   logic        m_waitrequest    [2];
   logic [63:0] m_readdata       [2];
   logic        m_readdatavalid  [2];
   logic [13:0] mem_address;
   logic        mem_chipselect;
   logic        mem_write;
   logic [7:0]  mem_byteenable;
   logic [63:0] mem_writedata;
   logic [63:0] mem_readdata;

   bit [63:0]   mem    [16384];
   bit [63:0]   shadow [16384];

   int          tests = 0;
   int          fails = 0;
   int          m_last;

   logic [13:0] cmd_addr [2];
   logic [3:0]  cmd_bc   [2];
   logic        cmd_rd   [2];
   logic        cmd_wr   [2];
   logic        cmd_req  [2];
   int          stall_at [2];
   int          stall_n  [2];
   logic [63:0] wd [2][16];
   logic [7:0]  wb [2][16];

   int          exp_grant [$];
   logic [63:0] exp_rd0 [$];
   logic [63:0] exp_rd1 [$];
   wr_t         exp_wr [$];

   onchip_memory_arbiter dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0_address       (m_address[0]),
      .m0_burstcount    (m_burstcount[0]),
      .m0_read          (m_read[0]),
      .m0_write         (m_write[0]),
      .m0_writedata     (m_writedata[0]),
      .m0_byteenable    (m_byteenable[0]),
      .m0_waitrequest   (m_waitrequest[0]),
      .m0_readdata      (m_readdata[0]),
      .m0_readdatavalid (m_readdatavalid[0]),
      .m1_address       (m_address[1]),
      .m1_burstcount    (m_burstcount[1]),
      .m1_read          (m_read[1]),
      .m1_write         (m_write[1]),
      .m1_writedata     (m_writedata[1]),
      .m1_byteenable    (m_byteenable[1]),
      .m1_waitrequest   (m_waitrequest[1]),
      .m1_readdata      (m_readdata[1]),
      .m1_readdatavalid (m_readdatavalid[1]),
      .mem_address      (mem_address),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_byteenable   (mem_byteenable),
      .mem_writedata    (mem_writedata),
      .mem_readdata     (mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory behind the port: byte-enabled write, one-cycle registered read.
   always @(posedge clk) begin
      if (mem_chipselect === 1'b1 && mem_write === 1'b1)
         for (int b = 0; b < 8; b++)
            if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      mem_readdata <= mem[mem_address];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Burst-level model: apply one master's whole burst to the shadow memory.
   task automatic plan(input int id, output int dur);
      int n;
      logic [13:0] a;
      n = (cmd_bc[id] == 4'd0) ? 1 : int'(cmd_bc[id]);
      exp_grant.push_back(id);
      for (int k = 0; k < n; k++) begin
         a = cmd_addr[id] + 14'(k);
         if (cmd_wr[id]) begin
            exp_wr.push_back('{a: a, d: wd[id][k], be: wb[id][k]});
            for (int b = 0; b < 8; b++)
               if (wb[id][k][b]) shadow[a][b*8 +: 8] = wd[id][k][b*8 +: 8];
         end else if (id == 0) exp_rd0.push_back(shadow[a]);
         else exp_rd1.push_back(shadow[a]);
      end
      dur = n + ((cmd_wr[id] && stall_at[id] > 0 && stall_at[id] < n) ? stall_n[id] : 0);
   endtask

   task automatic drive(input int id, output int lat);
      int n, k, cyc;
      n = (cmd_bc[id] == 4'd0) ? 1 : int'(cmd_bc[id]);
      m_address[id]    = cmd_addr[id];
      m_burstcount[id] = cmd_bc[id];
      m_read[id]       = cmd_rd[id];
      m_write[id]      = cmd_wr[id];
      m_writedata[id]  = wd[id][0];
      m_byteenable[id] = wb[id][0];
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (m_waitrequest[id] !== 1'b0 && cyc < 100);
      lat = cyc;
      if (m_waitrequest[id] !== 1'b0) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout m%0d: got waitrequest=%b after %0d cycles expected 0", id, m_waitrequest[id], cyc);
         m_read[id]  = 1'b0;
         m_write[id] = 1'b0;
      end else if (!cmd_wr[id]) begin
         @(posedge clk); #1;
         m_read[id] = 1'b0;
      end else begin
         k = 0;
         while (k < n) begin
            @(posedge clk); #1;
            k++;
            m_read[id] = 1'b0;
            if (k == n) m_write[id] = 1'b0;
            else begin
               if (k == stall_at[id]) begin
                  m_write[id] = 1'b0;
                  repeat (stall_n[id]) begin @(posedge clk); #1; end
               end
               m_write[id]      = 1'b1;
               m_writedata[id]  = wd[id][k];
               m_byteenable[id] = wb[id][k];
               @(negedge clk);
            end
         end
         @(negedge clk);
         chk($sformatf("wr_end_idle_wait m%0d", id), 64'(m_waitrequest[id]), 64'd1);
         chk("wr_end_idle_cs", 64'(mem_chipselect), 64'd0);
      end
   endtask

   task automatic run_round();
      int order[$];
      int dur[2];
      int l0, l1, first;
      order = {};
      dur = '{0, 0};
      l0 = 0;
      l1 = 0;
      if (cmd_req[0] && cmd_req[1]) begin
         first  = 1 - m_last;
         order  = {first, 1 - first};
         m_last = 1 - first;
      end else if (cmd_req[0]) begin
         order  = {0};
         m_last = 0;
      end else begin
         order  = {1};
         m_last = 1;
      end
      foreach (order[i]) plan(order[i], dur[order[i]]);
      fork
         begin if (cmd_req[0]) drive(0, l0); end
         begin if (cmd_req[1]) drive(1, l1); end
      join
      chk("grant_lat_first", 64'((order[0] == 0) ? l0 : l1), 64'd2);
      if (order.size() == 2)
         chk("grant_lat_second", 64'((order[1] == 0) ? l0 : l1), 64'(dur[order[0]] + 3));
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int id, input logic [13:0] a, input logic [3:0] bc,
                          input logic rd, input logic wr, input int sa, input int sn);
      cmd_req[id]  = 1'b1;
      cmd_addr[id] = a;
      cmd_bc[id]   = bc;
      cmd_rd[id]   = rd;
      cmd_wr[id]   = wr;
      stall_at[id] = sa;
      stall_n[id]  = sn;
      for (int k = 0; k < 16; k++) begin
         wd[id][k] = {$urandom, $urandom};
         wb[id][k] = 8'hFF;
      end
   endtask

   // Monitor: grant order, read data and timing, memory writes.
   initial begin
      int   cyc;
      int   gcyc [2];
      int   rcnt [2];
      logic prev_w [2];
      logic [63:0] e;
      wr_t  w;
      int   g;
      cyc = 0;
      gcyc = '{0, 0};
      rcnt = '{0, 0};
      prev_w = '{1'b1, 1'b1};
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (m_waitrequest[i] === 1'b0 && prev_w[i] === 1'b1) begin
               if (exp_grant.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_grant: got grant to m%0d expected none", i);
               end else begin
                  g = exp_grant.pop_front();
                  chk("grant_order", 64'(i), 64'(g));
               end
               gcyc[i] = cyc;
               rcnt[i] = 0;
            end
            prev_w[i] = m_waitrequest[i];
            if (m_readdatavalid[i] === 1'b1) begin
               chk($sformatf("rdv_timing m%0d", i), 64'(cyc), 64'(gcyc[i] + 1 + rcnt[i]));
               rcnt[i]++;
               if ((i == 0 && exp_rd0.size() == 0) || (i == 1 && exp_rd1.size() == 0)) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_rdv m%0d: got readdatavalid=1 expected 0", i);
               end else begin
                  e = (i == 0) ? exp_rd0.pop_front() : exp_rd1.pop_front();
                  chk($sformatf("readdata m%0d", i), m_readdata[i], e);
               end
            end
         end
         if (mem_chipselect === 1'b1 && mem_write === 1'b1) begin
            if (exp_wr.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got write at %h expected none", mem_address);
            end else begin
               w = exp_wr.pop_front();
               chk("wr_addr", 64'(mem_address), 64'(w.a));
               chk("wr_data", mem_writedata, w.d);
               chk("wr_be", 64'(mem_byteenable), 64'(w.be));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] wrap_addr [3];
      int c, t, cyc;
      reset_n = 1'b0;
      m_last  = 1;
      for (int i = 0; i < 2; i++) begin
         m_address[i] = '0; m_burstcount[i] = '0; m_read[i] = 1'b0; m_write[i] = 1'b0;
         m_writedata[i] = '0; m_byteenable[i] = '0; cmd_req[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wait0", 64'(m_waitrequest[0]), 64'd1);
      chk("rst_wait1", 64'(m_waitrequest[1]), 64'd1);
      chk("rst_rdv0", 64'(m_readdatavalid[0]), 64'd0);
      chk("rst_rdv1", 64'(m_readdatavalid[1]), 64'd0);
      chk("rst_cs", 64'(mem_chipselect), 64'd0);
      chk("rst_we", 64'(mem_write), 64'd0);
      chk("rst_addr", 64'(mem_address), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Contention out of reset: m0 first, then alternate.
      for (int r = 0; r < 4; r++) begin
         set_cmd(0, 14'($urandom_range(0, 63)), 4'd2, 1'b1, 1'b0, 0, 0);
         set_cmd(1, 14'($urandom_range(0, 63)), 4'd2, 1'b1, 1'b0, 0, 0);
         run_round();
      end

      // Single read of a known word.
      set_cmd(0, 14'h010, 4'd1, 1'b0, 1'b1, 0, 0);
      wd[0][0] = 64'h0123456789ABCDEF;
      cmd_req[1] = 1'b0;
      run_round();
      set_cmd(0, 14'h010, 4'd1, 1'b1, 1'b0, 0, 0);
      run_round();

      // Write burst with a two-cycle stall after beat 1, then read back.
      cmd_req[0] = 1'b0;
      set_cmd(1, 14'h100, 4'd4, 1'b0, 1'b1, 2, 2);
      run_round();
      set_cmd(1, 14'h100, 4'd4, 1'b1, 1'b0, 0, 0);
      run_round();

      // Wrap at the top of the address space.
      cmd_req[1] = 1'b0;
      set_cmd(0, 14'h3FFF, 4'd3, 1'b0, 1'b1, 0, 0);
      run_round();
      set_cmd(0, 14'h3FFF, 4'd3, 1'b1, 1'b0, 0, 0);
      c = 0;
      fork
         run_round();
         repeat (12) begin
            @(negedge clk);
            if (mem_chipselect === 1'b1 && c < 3) begin
               wrap_addr[c] = mem_address;
               c++;
            end
         end
      join
      chk("wrap_addr0", 64'(wrap_addr[0]), 64'h3FFF);
      chk("wrap_addr1", 64'(wrap_addr[1]), 64'h0000);
      chk("wrap_addr2", 64'(wrap_addr[2]), 64'h0001);

      // Burstcount 0 and read+write together.
      set_cmd(0, 14'h040, 4'd0, 1'b1, 1'b1, 0, 0);
      run_round();
      set_cmd(0, 14'h040, 4'd0, 1'b1, 1'b0, 0, 0);
      run_round();
      set_cmd(0, 14'h041, 4'd2, 1'b1, 1'b1, 1, 1);
      run_round();
      set_cmd(0, 14'h040, 4'd3, 1'b1, 1'b0, 0, 0);
      run_round();

      // Randomized rounds.
      for (int r = 0; r < 80; r++) begin
         for (int i = 0; i < 2; i++) begin
            t = $urandom_range(0, 2);
            set_cmd(i, ($urandom_range(0, 3) == 0) ? 14'h3FF0 + 14'($urandom_range(0, 15))
                                                   : 14'($urandom_range(0, 255)),
                    4'($urandom_range(0, 15)), t != 1, t != 0,
                    $urandom_range(0, 4), $urandom_range(0, 3));
            for (int k = 0; k < 16; k++)
               if ($urandom_range(0, 1) == 1) wb[i][k] = 8'($urandom);
            cmd_req[i] = ($urandom_range(0, 2) != 0);
         end
         if (!cmd_req[0] && !cmd_req[1]) cmd_req[0] = 1'b1;
         run_round();
      end

      // Reset in the middle of an 8-beat read: only beats 0 and 1 come back.
      exp_grant.push_back(0);
      exp_rd0.push_back(shadow[14'h080]);
      exp_rd0.push_back(shadow[14'h081]);
      m_address[0] = 14'h080; m_burstcount[0] = 4'd8; m_read[0] = 1'b1; m_write[0] = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (m_waitrequest[0] !== 1'b0 && cyc < 100);
      chk("rst_burst_accept", 64'(m_waitrequest[0]), 64'd0);
      @(posedge clk); #1;
      m_read[0] = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst_burst_beat2_addr", 64'(mem_address), 64'h082);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_burst_wait0", 64'(m_waitrequest[0]), 64'd1);
      chk("rst_burst_rdv0", 64'(m_readdatavalid[0]), 64'd0);
      chk("rst_burst_cs", 64'(mem_chipselect), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_last  = 1;
      set_cmd(0, 14'h0C0, 4'd2, 1'b0, 1'b1, 0, 0);
      set_cmd(1, 14'h0D0, 4'd2, 1'b0, 1'b1, 0, 0);
      run_round();

      repeat (5) @(posedge clk);
      chk("grant_queue_empty", 64'(exp_grant.size()), 64'd0);
      chk("rd0_queue_empty", 64'(exp_rd0.size()), 64'd0);
      chk("rd1_queue_empty", 64'(exp_rd1.size()), 64'd0);
      chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
